// File: rtl/adder_pkg.sv
// Shared constants and the per-stage pipeline record for the sliced adder.
package adder_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_SLICES = 2;
  localparam int MAX_W      = 64;

  // Operands are kept right-aligned: each stage shifts out the slice it consumed.
  typedef struct packed {
    logic             vld;
    logic             carry;
    logic             ovf;
    logic [MAX_W-1:0] sum;
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
  } stage_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple of full adders; one instance per pipeline stage.
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co = w_c[W];

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract split into SLICES registered bit-slices; latency SLICES cycles.
// An unaccepted result freezes every occupied stage and drops in_ready; bubbles still flow.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SLICES = DEF_SLICES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE_W = WIDTH / SLICES;

  stage_t             r_stg [SLICES];
  stage_t             w_in  [SLICES];
  stage_t             w_nxt [SLICES];
  logic [SLICE_W-1:0] w_s   [SLICES];
  logic [SLICES-1:0]  w_co;
  logic [SLICES-1:0]  w_en;
  logic               w_stall;
  logic [WIDTH-1:0]   w_y_eff;
  logic [SLICES:0]    w_unused;

  assign w_stall  = r_stg[SLICES-1].vld && !out_ready;
  assign in_ready = !w_stall;
  assign w_y_eff  = sub ? ~y : y;

  // Subtract is x + ~y + !cin, so the carry-in is cin flipped by sub.
  assign w_in[0] = '{
    vld:   in_valid && in_ready,
    carry: cin ^ sub,
    ovf:   1'b0,
    sum:   '0,
    a:     MAX_W'(x),
    b:     MAX_W'(w_y_eff)
  };

  for (genvar k = 0; k < SLICES; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign w_in[k] = r_stg[k-1];
    end

    adder_slice #(.W(SLICE_W)) u_slice (
      .a  (w_in[k].a[SLICE_W-1:0]),
      .b  (w_in[k].b[SLICE_W-1:0]),
      .ci (w_in[k].carry),
      .s  (w_s[k]),
      .co (w_co[k])
    );

    // ovf is recomputed every stage; only the top slice's value survives to the output.
    assign w_nxt[k] = '{
      vld:   w_in[k].vld && !w_stall,
      carry: w_co[k],
      ovf:   (w_in[k].a[SLICE_W-1] == w_in[k].b[SLICE_W-1]) &&
             (w_s[k][SLICE_W-1] != w_in[k].a[SLICE_W-1]),
      sum:   w_in[k].sum | (MAX_W'(w_s[k]) << (k * SLICE_W)),
      a:     w_in[k].a >> SLICE_W,
      b:     w_in[k].b >> SLICE_W
    };

    // Occupied stages hold on stall; empty ones keep loading bubbles.
    assign w_en[k]     = !w_stall || !r_stg[k].vld;
    assign w_unused[k] = w_in[k].ovf;
  end

  assign w_unused[SLICES] = ^{r_stg[SLICES-1].a, r_stg[SLICES-1].b, r_stg[SLICES-1].sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SLICES; k++) r_stg[k] <= '0;
    end else begin
      for (int k = 0; k < SLICES; k++) begin
        if (w_en[k]) r_stg[k] <= w_nxt[k];
      end
    end
  end

  assign out_valid = r_stg[SLICES-1].vld;
  assign sum       = r_stg[SLICES-1].sum[WIDTH-1:0];
  assign cout      = r_stg[SLICES-1].carry;
  assign ovf       = r_stg[SLICES-1].ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder at WIDTH=8, SLICES=2.
module tb_pipelined_adder;

  localparam int W   = 8;
  localparam int LAT = 2;

  logic         clk, rst_n, in_valid, in_ready, cin, sub;
  logic         out_valid, out_ready, cout, ovf;
  logic [W-1:0] x, y, sum;

  typedef struct {
    logic [9:0] res;
    int         cyc;
    bit         lat;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_err  = 0;
  int   cyc    = 0;
  int   n_id   = 0;
  int   n_out  = 0;
  int   n_drop = 0;
  bit   lat_chk = 1'b0;

  pipelined_adder #(.WIDTH(W), .SLICES(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Golden result {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [9:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c, input logic s);
    int   ur, sr;
    logic co, ov;
    if (!s) begin
      ur = int'(a) + int'(b) + int'(c);
      sr = int'($signed(a)) + int'($signed(b)) + int'(c);
      co = (ur > 255);
    end else begin
      ur = int'(a) - int'(b) - int'(c);
      sr = int'($signed(a)) - int'($signed(b)) - int'(c);
      co = (ur >= 0);
    end
    ov = (sr > 127) || (sr < -128);
    return {ov, co, ur[7:0]};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          chk($sformatf("res%0d", e.id), 32'({ovf, cout, sum}), 32'(e.res));
          if (e.lat) chk($sformatf("lat%0d", e.id), cyc - e.cyc, LAT);
        end
      end
      if (in_valid && in_ready) begin
        e.res = golden(x, y, cin, sub);
        e.cyc = cyc;
        e.lat = lat_chk;
        e.id  = n_id;
        exp_q.push_back(e);
        n_id++;
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    int waited;
    waited = 0;
    x = a; y = b; cin = c; sub = s; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      x = W'($urandom); y = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; cin = 1'b0; sub = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       32'(sum),       32'd0);
    chk("rst_cout",      32'(cout),      32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    lat_chk = 1'b1;
    drive(8'hFF, 8'h01, 1'b0, 1'b0);
    drive(8'h7F, 8'h01, 1'b0, 1'b0);
    drive(8'h05, 8'h07, 1'b0, 1'b1);
    drive(8'h80, 8'h01, 1'b1, 1'b1);
    idle(4);
    for (int i = 0; i < 16; i++) drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    idle(4);

    lat_chk = 1'b0;
    out_ready = 1'b0;
    drive(8'h11, 8'h22, 1'b0, 1'b0);
    drive(8'h33, 8'h44, 1'b1, 1'b1);
    x = 8'hA5; y = 8'h5A; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready",  32'(in_ready),  32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      if (exp_q.size() != 0) chk("stall_hold", 32'({ovf, cout, sum}), 32'(exp_q[0].res));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drive(8'hA5, 8'h5A, 1'b1, 1'b0);
    idle(4);

    drive(8'hC3, 8'h3C, 1'b0, 1'b0);
    drive(8'h9A, 8'h17, 1'b1, 1'b1);
    chk("inflight_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    n_drop += exp_q.size();
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum",       32'(sum),       32'd0);
    chk("midrst_cout",      32'(cout),      32'd0);
    chk("midrst_ovf",       32'(ovf),       32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);
    lat_chk = 1'b1;
    drive(8'h12, 8'h34, 1'b0, 1'b0);
    idle(4);

    lat_chk = 1'b0;
    fork
      for (int i = 0; i < 20; i++) drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      begin
        repeat (40) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    in_valid  = 1'b0;

    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("deliveries",  32'(n_out),        32'(n_id - n_drop));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/sum width in bits, minimum 2.
REQ-002 SHALL have parameter SLICES, default 2: pipeline stages; WIDTH divisible by SLICES; SLICE_W = WIDTH/SLICES.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: operands present this cycle.
REQ-006 SHALL have port in_ready, output, 1: block accepts operands this cycle.
REQ-007 SHALL have port x, input, WIDTH: operand A.
REQ-008 SHALL have port y, input, WIDTH: operand B.
REQ-009 SHALL have port cin, input, 1: carry-in (add) or borrow-in (sub).
REQ-010 SHALL have port sub, input, 1: 0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid, output, 1: result present.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-013 SHALL have port sum, output, WIDTH: result.
REQ-014 SHALL have port cout, output, 1: carry out of the MSB.
REQ-015 SHALL have port ovf, output, 1: two's-complement signed overflow.

Function
REQ-016 SHALL accept a transfer when in_valid && in_ready, and deliver when out_valid && out_ready.
REQ-017 SHALL compute, when sub=0: {cout,sum} = x + y + cin, modulo 2^(WIDTH+1).
REQ-018 SHALL compute, when sub=1: {cout,sum} = x + ~y + !cin, i.e. x - y - cin, with cout=1 meaning no borrow.
REQ-019 SHALL set ovf = (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]), with B' the effective (possibly inverted) y.
REQ-020 SHALL have stage k (0..SLICES-1) add bit slice k and register its sum bits, carry, valid bit and the unconsumed upper operand bits.
REQ-021 SHALL have latency exactly SLICES cycles from accept to out_valid when not stalled.
REQ-022 SHALL sustain throughput of one operation per cycle with no bubbles when out_ready=1.
REQ-023 SHALL define stall = out_valid && !out_ready; while stalled, every stage holds its contents.
REQ-024 SHALL drive in_ready = !stall, combinationally.
REQ-025 SHALL let empty stages propagate bubbles (valid=0) and SHALL NOT freeze them on stall.
REQ-026 SHALL hold sum, cout and ovf stable while out_valid && !out_ready.
REQ-027 SHALL deliver results in acceptance order, with no loss or duplication.
REQ-028 SHALL ignore x, y, cin and sub when in_valid=0.
REQ-029 SHALL, when SLICES=1, behave as a single registered stage with latency 1.

Reset
REQ-030 SHALL, while rst_n=0, immediately clear all stage valid bits, out_valid, sum, cout and ovf to 0.
REQ-031 SHALL, on reset mid-operation, discard in-flight operations with no output produced for them.
REQ-032 SHALL accept the first operation on the first rising edge after rst_n deasserts, with in_ready=1.

Structure
REQ-033 SHALL place the default WIDTH/SLICES constants and a stage record typedef (valid, carry, partial sum, remaining operands) in a shared package, adder_pkg.
REQ-034 SHALL instantiate sub-module adder_slice (SLICE_W-bit ripple of full adders: a, b, ci -> s, co), once per stage.

Verification (WIDTH=8, SLICES=2)
REQ-035 SHALL cover: add x=0xFF, y=0x01, cin=0 -> after 2 cycles sum=0x00, cout=1, ovf=0.
REQ-036 SHALL cover: add x=0x7F, y=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; sub x=0x05, y=0x07, cin=0 -> sum=0xFE, cout=0, ovf=0.
REQ-037 SHALL cover: 16 back-to-back random ops with out_ready=1 -> 16 results on consecutive cycles, matching the golden model in order.
REQ-038 SHALL cover: out_ready=0 for 4 cycles while in_valid=1 -> in_ready=0 once out_valid rises, held result stable, no loss after release.
REQ-039 SHALL cover: rst_n pulsed low with 2 ops in flight -> out_valid=0 immediately, no stale result after release, next op correct.
REQ-040 SHALL cover: sub x=0x80, y=0x01, cin=1 -> sum=0x7E, cout=1, ovf=1.
